// File: rtl/timer_event_receiver_if.sv
// -----------------------------------------------------------------------------
// timer_event_receiver_if
// Event handshake bundle between the timer event receiver and its consumer.
//   evt_valid    : at least one expiry event is pending
//   evt_ready    : consumer accepts one event on a clk edge with evt_valid
//   pending      : number of unconsumed events (CNT_W bits)
//   overflow     : sticky lost-event flag
//   clr_overflow : synchronous overflow clear
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface timer_event_receiver_if #(
  parameter int CNT_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             clr_overflow;

  modport master (
    output evt_valid,
    output pending,
    output overflow,
    input  evt_ready,
    input  clr_overflow
  );

  modport slave (
    input  evt_valid,
    input  pending,
    input  overflow,
    output evt_ready,
    output clr_overflow
  );
endinterface

// File: rtl/timer_event_receiver.sv
// -----------------------------------------------------------------------------
// timer_event_receiver
// Synchronizes the asynchronous countdown-timer expiry flag, turns each rising
// edge into one event and queues events in a saturating pending counter that
// a consumer drains through a valid/ready handshake.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bandera_in : timer expiry flag, asynchronous to clk
//   evt_if     : event handshake (timer_event_receiver_if.master)
//
// Parameters:
//   CNT_W      : pending counter width
//   FILTER_LEN : glitch filter length in clk cycles (2..15), used only when
//                EVT_GLITCH_FILTER_EN is defined
//
// Build option: define EVT_GLITCH_FILTER_EN to insert a glitch filter between
// the synchronizer and the edge detector.
// -----------------------------------------------------------------------------
module timer_event_receiver #(
  parameter int CNT_W      = 4,
  parameter int FILTER_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bandera_in,
  timer_event_receiver_if.master evt_if
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

`ifdef EVT_GLITCH_FILTER_EN
  // After reset the synchronizer and filter hold stale lows; the history
  // register is held high until both have had time to reflect the real input.
  localparam int PRIME_LEN = 2 + FILTER_LEN;
  localparam logic [3:0] FILT_TC = 4'(FILTER_LEN - 1);
`else
  localparam int PRIME_LEN = 2;
`endif
  localparam logic [4:0] PRIME_INIT = 5'(PRIME_LEN);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic [4:0]       prime_q, prime_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             level;
  logic             evt;
  logic             xfer;
  logic             sat;

  // Two-flop synchronizer
  always_comb begin
    sync1_d = bandera_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef EVT_GLITCH_FILTER_EN
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;

  // Filtered level follows the synchronized level only after FILTER_LEN
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FILT_TC) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  // Rising-edge detect with reset-high history
  always_comb begin
    evt     = level & ~hist_q;
    prime_d = (prime_q != 5'd0) ? (prime_q - 5'd1) : 5'd0;
    hist_d  = (prime_q != 5'd0) ? 1'b1 : level;
  end

  // Pending counter, handshake and sticky overflow
  always_comb begin
    xfer      = valid_q & evt_if.evt_ready;
    sat       = (pending_q == PEND_MAX);
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (evt_if.clr_overflow) begin
      ovf_d = 1'b0;
    end
    if (evt && !xfer) begin
      if (sat) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!evt && xfer) begin
      pending_d = pending_q - 1'b1;
    end
    // Registered valid mirrors the next count so evt_ready never reaches
    // evt_valid combinationally.
    valid_d = (pending_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q    <= 1'b1;
      prime_q   <= PRIME_INIT;
      pending_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      prime_q   <= prime_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign evt_if.evt_valid = valid_q;
  assign evt_if.pending   = pending_q;
  assign evt_if.overflow  = ovf_q;

endmodule

// File: tb/tb_timer_event_receiver.sv
module tb_timer_event_receiver;

  localparam int CNT_W = 4;
  localparam int FLEN  = 4;
`ifdef EVT_GLITCH_FILTER_EN
  localparam int LAT = 3 + FLEN;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bandera_in;
  int   checks = 0;
  int   errors = 0;

  timer_event_receiver_if #(.CNT_W(CNT_W)) evt_if ();

  timer_event_receiver #(
    .CNT_W      (CNT_W),
    .FILTER_LEN (FLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bandera_in (bandera_in),
    .evt_if     (evt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // One clean event pulse, long enough for the filter in either build
  task automatic pulse();
    bandera_in = 1'b1;
    ticks(LAT + 2);
    bandera_in = 1'b0;
    ticks(LAT + 2);
  endtask

  initial begin
    reset               = 1'b0;
    bandera_in          = 1'b0;
    evt_if.evt_ready    = 1'b0;
    evt_if.clr_overflow = 1'b0;

    // Reset state
    ticks(3);
    check("rst_pending", 32'(evt_if.pending), 0);
    check("rst_valid", 32'(evt_if.evt_valid), 0);
    check("rst_overflow", 32'(evt_if.overflow), 0);
    reset = 1'b1;
    ticks(10);
    check("idle_pending", 32'(evt_if.pending), 0);

    // Single long high level -> one event at the LAT-th sampling edge
    bandera_in = 1'b1;
    ticks(LAT - 1);
    check("lat_before", 32'(evt_if.pending), 0);
    tick();
    check("lat_at", 32'(evt_if.pending), 1);
    check("lat_valid", 32'(evt_if.evt_valid), 1);
    ticks(10 - LAT);
    bandera_in = 1'b0;
    ticks(LAT + 4);
    check("no_second_evt", 32'(evt_if.pending), 1);

    // Consume it, then ready at zero has no effect
    evt_if.evt_ready = 1'b1;
    tick();
    check("consume_pending", 32'(evt_if.pending), 0);
    check("consume_valid", 32'(evt_if.evt_valid), 0);
    ticks(3);
    check("no_underflow", 32'(evt_if.pending), 0);
    evt_if.evt_ready = 1'b0;

    // 20 pulses: saturation and overflow
    for (int i = 1; i <= 20; i++) begin
      pulse();
      if (i == 15) begin
        check("p15_pending", 32'(evt_if.pending), 15);
        check("p15_overflow", 32'(evt_if.overflow), 0);
      end
      if (i == 16) begin
        check("p16_pending", 32'(evt_if.pending), 15);
        check("p16_overflow", 32'(evt_if.overflow), 1);
      end
    end
    check("p20_pending", 32'(evt_if.pending), 15);
    check("p20_overflow", 32'(evt_if.overflow), 1);
    evt_if.clr_overflow = 1'b1;
    tick();
    evt_if.clr_overflow = 1'b0;
    check("clr_overflow", 32'(evt_if.overflow), 0);
    check("clr_pending", 32'(evt_if.pending), 15);

    // Overflow set and clear on the same edge: set wins
    bandera_in = 1'b1;
    ticks(LAT - 1);
    evt_if.clr_overflow = 1'b1;
    tick();
    evt_if.clr_overflow = 1'b0;
    check("set_wins", 32'(evt_if.overflow), 1);
    bandera_in = 1'b0;
    ticks(LAT + 2);
    evt_if.clr_overflow = 1'b1;
    tick();
    evt_if.clr_overflow = 1'b0;
    check("clr_again", 32'(evt_if.overflow), 0);

    // Event and transfer on the same edge at saturation
    bandera_in = 1'b1;
    ticks(LAT - 1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("sat_simul_pending", 32'(evt_if.pending), 15);
    check("sat_simul_overflow", 32'(evt_if.overflow), 0);
    tick();
    check("sat_simul_after", 32'(evt_if.pending), 15);
    bandera_in = 1'b0;
    ticks(LAT + 2);

    // Drain to 2
    evt_if.evt_ready = 1'b1;
    ticks(13);
    evt_if.evt_ready = 1'b0;
    check("drain_pending", 32'(evt_if.pending), 2);

    // Event and transfer on the same edge at 2
    bandera_in = 1'b1;
    ticks(LAT - 1);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("simul_pending", 32'(evt_if.pending), 2);
    tick();
    check("simul_after", 32'(evt_if.pending), 2);
    bandera_in = 1'b0;
    ticks(LAT + 2);

    // Build up to 5, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) pulse();
    check("pre_reset_pending", 32'(evt_if.pending), 5);
    bandera_in = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_pending", 32'(evt_if.pending), 0);
    check("async_rst_valid", 32'(evt_if.evt_valid), 0);
    ticks(2);
    #2;
    reset = 1'b1;
    ticks(20);
    check("held_high_no_evt", 32'(evt_if.pending), 0);
    bandera_in = 1'b0;
    ticks(LAT + 2);
    check("fall_no_evt", 32'(evt_if.pending), 0);
    bandera_in = 1'b1;
    ticks(LAT - 1);
    check("rerise_before", 32'(evt_if.pending), 0);
    tick();
    check("rerise_evt", 32'(evt_if.pending), 1);
    ticks(3);
    bandera_in = 1'b0;
    ticks(LAT + 2);

`ifdef EVT_GLITCH_FILTER_EN
    // 3-cycle glitch is filtered out; 4-cycle pulse gives one event at 3+4
    bandera_in = 1'b1;
    ticks(3);
    bandera_in = 1'b0;
    ticks(12);
    check("glitch_ignored", 32'(evt_if.pending), 1);
    bandera_in = 1'b1;
    ticks(4);
    bandera_in = 1'b0;
    ticks(2);
    check("filt_lat_before", 32'(evt_if.pending), 1);
    tick();
    check("filt_lat_at", 32'(evt_if.pending), 2);
    ticks(12);
    check("filt_single", 32'(evt_if.pending), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_event_receiver.md
TIMER_EVENT_RECEIVER -- requirements
Module: timer_event_receiver

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the width of the pending-event counter.
REQ-002 The block SHALL have parameter FILTER_LEN, default 4, setting the glitch-filter length in clk cycles (range 2..15).
REQ-003 The block SHALL have port clk  input  1  as its single system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  as an asynchronous, active-low reset.
REQ-005 The block SHALL have port bandera_in  input  1  carrying the expiry flag from the countdown timer; it is asynchronous to clk.
REQ-006 The block SHALL have port evt_valid  output  1  indicating that at least one expiry event is pending.
REQ-007 The block SHALL have port evt_ready  input  1  through which the consumer accepts one event.
REQ-008 The block SHALL have port pending  output  CNT_W  giving the number of unconsumed events.
REQ-009 The block SHALL have port overflow  output  1  as a sticky flag marking a lost event.
REQ-010 The block SHALL have port clr_overflow  input  1  as a synchronous overflow clear.

Function
REQ-011 The block SHALL pass bandera_in through a two-flop synchronizer before any other use.
REQ-012 The block SHALL detect each rising edge of the synchronized (or filtered) level as exactly one event, whatever the high-level duration.
REQ-013 Without the filter, pending SHALL increment at the 3rd rising clk edge at which bandera_in is sampled high, counting the first sampling edge as 1.
REQ-014 evt_valid SHALL equal (pending != 0), driven from registered state with no combinational path from evt_ready.
REQ-015 A transfer SHALL occur on a clk edge where evt_valid and evt_ready are both 1; each transfer decrements pending by exactly 1.
REQ-016 A simultaneous event and transfer SHALL leave pending unchanged.
REQ-017 pending SHALL saturate at 2^CNT_W-1; an event at saturation with no transfer SHALL leave pending unchanged and set overflow.
REQ-018 An event at saturation with a simultaneous transfer SHALL leave pending at 2^CNT_W-1 and SHALL NOT set overflow.
REQ-019 evt_ready while pending == 0 SHALL have no effect; pending SHALL never wrap below 0.
REQ-020 overflow SHALL remain 1 until a clk edge with clr_overflow = 1; if set and clear occur on the same edge, set SHALL win.

Reset
REQ-021 While reset = 0, the synchronizer flops SHALL be held at 0, pending at 0, evt_valid at 0, overflow at 0, and the filter state at "low, count 0".
REQ-022 The edge-detect history register SHALL reset to 1, so a bandera_in held high through reset release produces no event until it goes low and high again.
REQ-023 Reset asserted mid-operation SHALL discard all pending and in-flight events immediately, independent of clk.

Configuration
REQ-024 With macro EVT_GLITCH_FILTER_EN defined, a filter SHALL sit between the synchronizer and the edge detector.
REQ-025 With EVT_GLITCH_FILTER_EN, the filtered level SHALL change only after the synchronized level has differed from it for FILTER_LEN consecutive clk cycles; any shorter excursion is ignored and restarts the count.
REQ-026 With EVT_GLITCH_FILTER_EN, the event latency of REQ-013 SHALL increase by exactly FILTER_LEN cycles.
REQ-027 Without EVT_GLITCH_FILTER_EN, the filter SHALL be absent, FILTER_LEN SHALL be ignored, and the latency SHALL be as in REQ-013.

Verification
REQ-028 The bench SHALL drive bandera_in high for 10 cycles with the filter off and evt_ready = 0 -> pending = 1 at the 3rd sampling edge, evt_valid = 1, and no second event.
REQ-029 The bench SHALL apply 20 separate bandera_in pulses with evt_ready = 0 and CNT_W = 4 -> pending = 15 and overflow = 1 after the 16th pulse; then pulse clr_overflow -> overflow = 0 and pending = 15.
REQ-030 The bench SHALL hold evt_ready = 1 and apply an event on the same edge as a transfer with pending = 2 -> pending stays 2; with pending = 15, the same stimulus -> pending stays 15 and overflow stays 0.
REQ-031 The bench SHALL, with EVT_GLITCH_FILTER_EN and FILTER_LEN = 4, apply a 3-cycle high glitch -> no event; then a 4-cycle high pulse -> exactly one event with latency 3+4 cycles.
REQ-032 The bench SHALL, with pending = 5, assert reset = 0 between clk edges -> pending = 0 and evt_valid = 0 immediately; release reset with bandera_in high -> no event until bandera_in falls and rises again.
